newton_sched: RTL

NEWTON_SCHED -- requirements
Module: newton_sched

---
 rtl/newton_pkg.sv | 23 ++
 rtl/newton_thresh.sv | 18 +
 rtl/newton_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/newton_pkg.sv
// Shared constants and types for the Newton iteration stage scheduler.
// OFF holds the per-stage cycle offset from an iteration's base cycle.
package newton_pkg;

   localparam int NUM_STG   = 7;
   localparam int STG_MUL   = 0;
   localparam int STG_AFIFO = 1;
   localparam int STG_ADD_A = 2;
   localparam int STG_DFIFO = 3;
   localparam int STG_DIV   = 4;
   localparam int STG_BFIFO = 5;
   localparam int STG_ADD_B = 6;

   // Entry 0 is the rightmost element: OFF[STG_MUL] = 0 ... OFF[STG_ADD_B] = 13.
   localparam logic [NUM_STG-1:0][3:0] OFF = {4'd13, 4'd12, 4'd6, 4'd5, 4'd3, 4'd2, 4'd0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/newton_thresh.sv
// Stage threshold T(i,s) = i*stride + OFF[s], evaluated at full TW width.
module newton_thresh
   import newton_pkg::*;
#(
   parameter int TW = 12,
   parameter int IW = 3
)(
   input  logic [5:0]    stride,
   input  logic [IW-1:0] iter,
   input  logic [2:0]    stg,
   output logic [TW-1:0] thr
);

   always_comb begin
      thr = TW'(iter) * TW'(stride) + TW'(OFF[stg]);
   end

endmodule

// File: rtl/newton_sched.sv
// Newton iteration scheduler: a run counter whose crossings of per-stage
// thresholds raise sticky stage enables for each configured iteration.
module newton_sched
   import newton_pkg::*;
#(
   parameter int NUM_ITER = 4,
   parameter int CNT_W    = 11,
   parameter int TAIL     = 4
)(
   input  logic                        clk,
   input  logic                        asyn_reset_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        stall,
   input  logic [5:0]                  cfg_stride,
   input  logic [2:0]                  cfg_iters,
   output logic [NUM_ITER*NUM_STG-1:0] en,
   output logic                        busy,
   output logic                        done,
   output logic                        cfg_err,
   output logic [CNT_W-1:0]            cnt
);

   // Threshold width covers the worst-case end point so no sum ever truncates.
   localparam int TMAX   = (NUM_ITER - 1) * 63 + 13 + TAIL;
   localparam int TW_MIN = $clog2(TMAX + 1);
   localparam int TW     = (TW_MIN > CNT_W + 1) ? TW_MIN : CNT_W + 1;
   localparam int IW     = $clog2(NUM_ITER + 1);
   localparam logic [TW-1:0] CNT_MAX = TW'({CNT_W{1'b1}});

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [NUM_ITER*NUM_STG-1:0] en_q, en_d;
   logic [5:0]                  stride_q, stride_d;
   logic [2:0]                  iters_q, iters_d;
   logic                        cfg_err_q, cfg_err_d;

   logic [2:0]                  eff_iters;
   logic [TW-1:0]               thr_new, thr_run;
   logic                        cfg_ok, at_end;
   logic [NUM_ITER-1:0][NUM_STG-1:0][TW-1:0] thr;

   always_comb begin
      eff_iters = cfg_iters;
      if (cfg_iters == 3'd0)
         eff_iters = 3'd1;
      else if (int'(cfg_iters) > NUM_ITER)
         eff_iters = 3'(NUM_ITER);
   end

   for (genvar i = 0; i < NUM_ITER; i++) begin : gen_iter
      for (genvar s = 0; s < NUM_STG; s++) begin : gen_stg
         newton_thresh #(.TW(TW), .IW(IW)) u_thr (
            .stride (stride_q),
            .iter   (IW'(i)),
            .stg    (3'(s)),
            .thr    (thr[i][s])
         );
      end
   end

   // End point of the requested config, checked before the run is accepted.
   newton_thresh #(.TW(TW), .IW(IW)) u_end_new (
      .stride (cfg_stride),
      .iter   (IW'(eff_iters - 3'd1)),
      .stg    (3'(STG_ADD_B)),
      .thr    (thr_new)
   );

   newton_thresh #(.TW(TW), .IW(IW)) u_end_run (
      .stride (stride_q),
      .iter   (IW'(iters_q - 3'd1)),
      .stg    (3'(STG_ADD_B)),
      .thr    (thr_run)
   );

   assign cfg_ok = (thr_new + TW'(TAIL)) <= CNT_MAX;
   assign at_end = TW'(cnt_q) == (thr_run + TW'(TAIL));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      en_d      = en_q;
      stride_d  = stride_q;
      iters_d   = iters_q;
      cfg_err_d = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         en_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (cfg_ok) begin
                     state_d  = ST_RUN;
                     cnt_d    = '0;
                     en_d     = '0;
                     stride_d = cfg_stride;
                     iters_d  = eff_iters;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  for (int i = 0; i < NUM_ITER; i++)
                     for (int s = 0; s < NUM_STG; s++)
                        if (i < int'(iters_q) && TW'(cnt_q) > thr[i][s])
                           en_d[i*NUM_STG+s] = 1'b1;
                  if (at_end)
                     state_d = ST_DONE;
                  else if (cnt_q != {CNT_W{1'b1}})
                     cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         en_q      <= '0;
         stride_q  <= 6'd0;
         iters_q   <= 3'd1;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         stride_q  <= stride_d;
         iters_q   <= iters_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign en      = en_q;
   assign cnt     = cnt_q;
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign cfg_err = cfg_err_q;

endmodule
